// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Snoops a time-multiplexed 7-segment display bus, filters each
//               digit dwell for stability, decodes it to BCD and publishes a
//               packed word once every digit has been refreshed.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    frame_valid,
  output logic [NUM_DIGITS-1:0]   digit_err
);

  localparam int                 c_RUN_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(STABLE_CYCLES);
  localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);

  // Sample stage and run-length counter
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic [c_RUN_W-1:0]      r_run;

  // Frame assembly state
  logic [4*NUM_DIGITS-1:0] r_slots;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic                    r_frame_valid;
  logic [NUM_DIGITS-1:0]   r_err;

  logic                    w_changed;
  logic [c_RUN_W-1:0]      w_run_nxt;
  logic                    w_capture_edge;
  logic                    w_onehot;
  logic                    w_capture;
  logic [3:0]              w_nib;
  logic                    w_illegal;
  logic [4*NUM_DIGITS-1:0] w_slots_nxt;
  logic [NUM_DIGITS-1:0]   w_seen_nxt;
  logic                    w_frame_done;
  logic [NUM_DIGITS-1:0]   w_err_set;

  assign w_changed = ({seg, dig_en} != {r_seg, r_dig});

  always_comb begin
    w_run_nxt = r_run;
    if (w_changed) begin
      w_run_nxt = c_RUN_ONE;
    end else if (r_run != c_RUN_MAX) begin
      w_run_nxt = r_run + c_RUN_ONE;
    end
  end

  // A fresh load can itself be the capturing edge when only one edge is required.
  assign w_capture_edge = (w_run_nxt == c_RUN_MAX) && ((r_run != c_RUN_MAX) || w_changed);
  assign w_onehot       = (dig_en != '0) && ((dig_en & (dig_en - NUM_DIGITS'(1))) == '0);
  assign w_capture      = w_capture_edge && w_onehot;

  always_comb begin
    w_nib     = 4'hE;
    w_illegal = 1'b0;
    case (seg)
      7'h3F:   w_nib = 4'h0;
      7'h06:   w_nib = 4'h1;
      7'h5B:   w_nib = 4'h2;
      7'h4F:   w_nib = 4'h3;
      7'h66:   w_nib = 4'h4;
      7'h6D:   w_nib = 4'h5;
      7'h7D:   w_nib = 4'h6;
      7'h07:   w_nib = 4'h7;
      7'h7F:   w_nib = 4'h8;
      7'h6F:   w_nib = 4'h9;
      7'h00:   w_nib = 4'hF;
      default: begin
        w_nib     = 4'hE;
        w_illegal = 1'b1;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
      assign w_slots_nxt[4*gi +: 4] = (w_capture && dig_en[gi]) ? w_nib : r_slots[4*gi +: 4];
    end
  endgenerate

  assign w_seen_nxt   = r_seen | (w_capture ? dig_en : '0);
  assign w_frame_done = w_capture && (&w_seen_nxt);
  assign w_err_set    = (w_capture && w_illegal) ? dig_en : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '0;
      r_dig <= '0;
      r_run <= '0;
    end else begin
      r_seg <= seg;
      r_dig <= dig_en;
      r_run <= w_run_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slots       <= '0;
      r_seen        <= '0;
      r_bcd         <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_slots       <= w_slots_nxt;
      r_seen        <= w_frame_done ? '0 : w_seen_nxt;
      r_frame_valid <= w_frame_done;
      if (w_frame_done) begin
        r_bcd <= w_slots_nxt;
      end
    end
  end

  // Set takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      r_err <= (r_err & ~{NUM_DIGITS{err_clr}}) | w_err_set;
    end
  end

  assign bcd_out     = r_bcd;
  assign frame_valid = r_frame_valid;
  assign digit_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_decoder
// Description : Scoreboard bench for seg7_scan_decoder with directed scans.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [6:0]  seg     = '0;
  logic [3:0]  dig_en  = '0;
  logic        err_clr = 1'b0;
  logic [15:0] bcd_out;
  logic        frame_valid;
  logic [3:0]  digit_err;

  int          n_total  = 0;
  int          n_pass   = 0;
  int          n_frames = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dig_en      (dig_en),
    .err_clr     (err_clr),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .digit_err   (digit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Present one digit for 'dwell' edges, then a one-edge blanking gap.
  task automatic show(input logic [3:0] en, input logic [6:0] s, input int dwell);
    dig_en = en;
    seg    = s;
    repeat (dwell) @(negedge clk);
    dig_en = '0;
    seg    = '0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (frame_valid !== 1'b0) begin
      n_frames++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL frame_unexpected actual=%h required=none", bcd_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("frame_bcd", {16'h0, bcd_out}, {16'h0, mon_exp});
      end
    end
  end

  initial begin
    // Reset with toggling inputs
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outputs", {11'h0, bcd_out, frame_valid, digit_err}, 32'h0);
      seg    = 7'($urandom);
      dig_en = 4'($urandom);
    end
    seg    = '0;
    dig_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic scan 1-2-3-4
    show(4'b1000, 7'h06, 5);
    show(4'b0100, 7'h5B, 5);
    show(4'b0010, 7'h4F, 5);
    exp_q.push_back(16'h1234);
    show(4'b0001, 7'h66, 5);

    // Short dwell on digit 1, then a full rescan
    show(4'b1000, 7'h06, 5);
    show(4'b0100, 7'h5B, 5);
    show(4'b0010, 7'h4F, 2);
    show(4'b0001, 7'h66, 5);
    repeat (3) @(negedge clk);
    #1 check("short_dwell_no_frame", n_frames, 1);
    exp_q.push_back(16'h1234);
    show(4'b0010, 7'h4F, 5);

    // Illegal pattern on digit 2, then error clear
    show(4'b1000, 7'h06, 5);
    show(4'b0100, 7'h49, 5);
    show(4'b0010, 7'h4F, 5);
    exp_q.push_back(16'h1E34);
    show(4'b0001, 7'h66, 5);
    check("err_set", {28'h0, digit_err}, 32'h4);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clear", {28'h0, digit_err}, 32'h0);

    // Multi-hot dig_en must not capture or flag
    dig_en = 4'b0011;
    seg    = 7'h7F;
    repeat (10) @(negedge clk);
    dig_en = '0;
    seg    = '0;
    @(negedge clk);
    check("multihot_no_err", {28'h0, digit_err}, 32'h0);
    show(4'b1000, 7'h66, 5);
    show(4'b0100, 7'h6D, 5);
    #1 check("multihot_seen_unchanged", n_frames, 3);
    show(4'b0010, 7'h7D, 5);
    exp_q.push_back(16'h4568);
    show(4'b0001, 7'h7F, 5);

    // Reset mid-frame discards the partial frame
    show(4'b1000, 7'h7F, 5);
    show(4'b0100, 7'h6F, 5);
    show(4'b0010, 7'h3F, 5);
    rst_n = 1'b0;
    #1 check("midreset_bcd", {16'h0, bcd_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    show(4'b0001, 7'h07, 5);
    repeat (2) @(negedge clk);
    #1 check("midreset_no_frame", n_frames, 4);
    show(4'b1000, 7'h7F, 5);
    show(4'b0100, 7'h6F, 5);
    exp_q.push_back(16'h8907);
    show(4'b0010, 7'h3F, 5);

    // Error set coinciding with err_clr: set wins
    dig_en = 4'b0001;
    seg    = 7'h49;
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_set_wins", {28'h0, digit_err}, 32'h1);
    dig_en = '0;
    seg    = '0;
    repeat (3) @(negedge clk);
    check("err_sticky", {28'h0, digit_err}, 32'h1);

    repeat (5) @(negedge clk);
    #1 check("frame_count", n_frames, 5);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
